// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader writing 32-bit words to imem,
// holding the CPU in reset until the image length and checksum verify.
module program_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RUN, S_ERR} state_e;
  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d, n_len;
  logic [7:0]        xor_q, xor_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [31:0]       addr_d, wdata_d;
  logic              acc, we_d, last_byte, last_word, oversize;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LEN0;
      len_q      <= '0;
      xor_q      <= '0;
      bidx_q     <= '0;
      asm_q      <= '0;
      words_q    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      bidx_q     <= bidx_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_reset  <= state_d != S_RUN;
      load_done  <= state_d == S_RUN;
      load_err   <= state_d == S_ERR;
    end
  end
  always_comb begin
    n_len     = {rx_data, len_q[7:0]};
    oversize  = 32'(n_len) > (32'd1 << ADDR_W);
    last_byte = bidx_q == 2'd3;
    last_word = 32'(words_q) + 32'd1 == 32'(len_q);
    state_d   = state_q;
    if (acc)
      case (state_q)
        S_LEN0:  state_d = S_LEN1;
        S_LEN1:  state_d = oversize ? S_ERR : n_len == 16'd0 ? S_CSUM : S_DATA;
        S_DATA:  state_d = last_byte && last_word ? S_CSUM : S_DATA;
        S_CSUM:  state_d = rx_data == xor_q ? S_RUN : S_ERR;
        default: state_d = state_q;
      endcase
  end
  // bytes arrive LSB first, so shifting right leaves {b2,b1,b0} when b3 lands
  always_comb begin
    rx_ready = !reset && (state_q == S_LEN0 || state_q == S_LEN1 ||
                          state_q == S_DATA || state_q == S_CSUM);
    acc      = rx_valid && rx_ready;
    we_d     = acc && state_q == S_DATA && last_byte;
    len_d    = !acc ? len_q : state_q == S_LEN0 ? {8'h00, rx_data} :
               state_q == S_LEN1 ? n_len : len_q;
    xor_d    = acc && state_q != S_CSUM ? xor_q ^ rx_data : xor_q;
    bidx_d   = acc && state_q == S_DATA ? bidx_q + 2'd1 : bidx_q;
    asm_d    = acc && state_q == S_DATA ? {rx_data, asm_q[23:8]} : asm_q;
    words_d  = words_q + {{ADDR_W{1'b0}}, we_d};
    addr_d   = we_d ? BASE_ADDR + (32'(words_q) << 2) : imem_addr;
    wdata_d  = we_d ? {rx_data, asm_q} : imem_wdata;
  end
  assign words_loaded = words_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven frame tests with a write scoreboard,
// plus throttled replay and mid-load reset sequences.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready, imem_we, cpu_reset, load_done, load_err;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  words_loaded;
  program_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  typedef struct { int n; bit done; bit err; int words; int writes; } vec_t;
  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  logic [7:0] fr [4][12];
  vec_t       vt [4];
  wr_t        q [$];
  int         n_cmp = 0, n_mis = 0, wcnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (imem_we === 1'b1) begin
      wr_t e;
      wcnt++;
      if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("wr_addr", imem_addr, e.a);
        chk("wr_data", imem_wdata, e.d);
      end
    end
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {imem_we, cpu_reset, load_done, load_err, rx_ready}, 5'b01000);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit thr);
    bit acc = 1'b0;
    if (thr) begin
      rx_valid = 1'b0; rx_data = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rx_data = b; rx_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask
  task automatic push_writes(input int t);
    int n = int'({fr[t][1], fr[t][0]});
    if (n <= 256)
      for (int i = 0; i < n; i++)
        q.push_back({32'(4 * i), fr[t][2+4*i+3], fr[t][2+4*i+2], fr[t][2+4*i+1], fr[t][2+4*i]});
  endtask
  task automatic run_frame(input int t, input bit thr, input bit rst);
    int w0;
    if (rst) do_reset();
    w0 = wcnt;
    push_writes(t);
    for (int i = 0; i < vt[t].n; i++) send(fr[t][i], thr);
    @(negedge clk);
    chk($sformatf("t%0d_done", t), 32'(load_done), 32'(vt[t].done));
    chk($sformatf("t%0d_err", t), 32'(load_err), 32'(vt[t].err));
    chk($sformatf("t%0d_cpu_reset", t), 32'(cpu_reset), 32'(!vt[t].done));
    chk($sformatf("t%0d_rx_ready", t), 32'(rx_ready), 32'd0);
    chk($sformatf("t%0d_words", t), 32'(words_loaded), 32'(vt[t].words));
    rx_data = 8'h5A; rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk($sformatf("t%0d_post_ready", t), 32'(rx_ready), 32'd0);
    chk($sformatf("t%0d_post_flags", t), {load_done, load_err, cpu_reset}, {vt[t].done, vt[t].err, !vt[t].done});
    chk($sformatf("t%0d_post_words", t), 32'(words_loaded), 32'(vt[t].words));
    rx_valid = 1'b0;
    chk($sformatf("t%0d_writes", t), 32'(wcnt - w0), 32'(vt[t].writes));
    chk($sformatf("t%0d_q_empty", t), 32'(q.size()), 32'd0);
  endtask
  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    fr[0] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73, 8'h00};
    fr[1] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h74, 8'h00};
    fr[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fr[3] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[0] = '{n: 11, done: 1'b1, err: 1'b0, words: 2, writes: 2};
    vt[1] = '{n: 11, done: 1'b0, err: 1'b1, words: 2, writes: 2};
    vt[2] = '{n: 3,  done: 1'b1, err: 1'b0, words: 0, writes: 0};
    vt[3] = '{n: 2,  done: 1'b0, err: 1'b1, words: 0, writes: 0};
    for (int t = 0; t < 4; t++) run_frame(t, 1'b0, 1'b1);
    run_frame(0, 1'b1, 1'b1);
    do_reset();
    q.push_back({32'h0, 32'h0050_0093});
    wcnt = 0;
    for (int i = 0; i < 7; i++) send(fr[0][i], 1'b0);
    @(negedge clk);
    chk("mid_words", 32'(words_loaded), 32'd1);
    chk("mid_flags", {load_done, load_err, cpu_reset, rx_ready}, 4'b0011);
    chk("mid_writes", 32'(wcnt), 32'd1);
    do_reset();
    run_frame(0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
